// File: rtl/mem_stage_if.sv
// rtl/mem_stage_if.sv - data-cache request/response bus between mem_stage and the data cache
interface mem_stage_if #(
   parameter int WORD_W = 32
);
   logic              dmemREN;
   logic              dmemWEN;
   logic [WORD_W-1:0] dmemaddr;
   logic [WORD_W-1:0] dmemstore;
   logic              dhit;
   logic [WORD_W-1:0] dmemload;

   // memory stage side: issues requests, receives the acknowledge and read data
   modport master (
      output dmemREN, dmemWEN, dmemaddr, dmemstore,
      input  dhit, dmemload
   );

   // cache side
   modport slave (
      input  dmemREN, dmemWEN, dmemaddr, dmemstore,
      output dhit, dmemload
   );
endinterface

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - EX/MEM latch, data-cache access FSM and MEM/WB latch; MEM_STALL_CNT_EN adds stall_cnt
module mem_stage #(
   parameter int WORD_W   = 32,
   parameter int REGSEL_W = 2,
   parameter int REGBIT_W = 5
) (
   input  logic                CLK,
   input  logic                nRST,
   input  logic                ihit,
   input  logic                flush,
   input  logic [WORD_W-1:0]   nPC_next,
   input  logic                dREN_next,
   input  logic                dWEN_next,
   input  logic                regWr_next,
   input  logic [REGSEL_W-1:0] regSel_next,
   input  logic [REGBIT_W-1:0] regDst_next,
   input  logic [WORD_W-1:0]   ALUOut_next,
   input  logic [WORD_W-1:0]   storeData,
   mem_stage_if.master         dbus,
   output logic                mem_stall,
   output logic [WORD_W-1:0]   wb_nPC,
   output logic [WORD_W-1:0]   wb_ALUOut,
   output logic [WORD_W-1:0]   wb_dload,
   output logic                wb_regWr,
   output logic [REGSEL_W-1:0] wb_regSel,
   output logic [REGBIT_W-1:0] wb_regDst
`ifdef MEM_STALL_CNT_EN
   ,
   output logic [31:0]         stall_cnt
`endif
);

   typedef logic [WORD_W-1:0]   word_t;
   typedef logic [REGSEL_W-1:0] regsel_t;
   typedef logic [REGBIT_W-1:0] regbit_t;

   typedef struct packed {
      word_t   npc;
      logic    dren;
      logic    dwen;
      logic    regwr;
      regsel_t regsel;
      regbit_t regdst;
      word_t   alu;
      word_t   sdata;
   } exmem_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t state_q;
   state_t state_d;
   exmem_t em_q;
   exmem_t em_in;
   word_t  hold_q;
   logic   adv;
   logic   in_mem;
   logic   rd_req;
   logic   wr_req;

   assign mem_stall = (state_q == S_WAIT);
   assign adv       = ihit & ~mem_stall;

   // Entry offered to EX/MEM: the execute outputs, or an all-zero bubble when squashed
   always_comb begin
      em_in = '0;
      if (!flush) begin
         em_in.npc    = nPC_next;
         em_in.dren   = dREN_next;
         em_in.dwen   = dWEN_next;
         em_in.regwr  = regWr_next;
         em_in.regsel = regSel_next;
         em_in.regdst = regDst_next;
         em_in.alu    = ALUOut_next;
         em_in.sdata  = storeData;
      end
   end

   assign in_mem = em_in.dren | em_in.dwen;

   // Access FSM state register
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state and request decode; a write takes priority over a read of the same entry
   always_comb begin
      state_d = state_q;
      rd_req  = 1'b0;
      wr_req  = 1'b0;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (adv) begin
               state_d = in_mem ? S_WAIT : S_IDLE;
            end
         end
         S_WAIT: begin
            wr_req = em_q.dwen;
            rd_req = em_q.dren & ~em_q.dwen;
            if (dbus.dhit) begin
               state_d = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign dbus.dmemREN   = rd_req;
   assign dbus.dmemWEN   = wr_req;
   assign dbus.dmemaddr  = em_q.alu;
   assign dbus.dmemstore = em_q.sdata;

   // EX/MEM latch: frozen while the access is outstanding
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         em_q <= '0;
      end else if (adv) begin
         em_q <= em_in;
      end
   end

   // Load data hold: captured on the read acknowledge, kept until the next read completes
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         hold_q <= '0;
      end else if (rd_req && dbus.dhit) begin
         hold_q <= dbus.dmemload;
      end
   end

   // MEM/WB latch
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         wb_nPC    <= '0;
         wb_ALUOut <= '0;
         wb_dload  <= '0;
         wb_regWr  <= 1'b0;
         wb_regSel <= '0;
         wb_regDst <= '0;
      end else if (adv) begin
         wb_nPC    <= em_q.npc;
         wb_ALUOut <= em_q.alu;
         wb_dload  <= hold_q;
         wb_regWr  <= em_q.regwr;
         wb_regSel <= em_q.regsel;
         wb_regDst <= em_q.regdst;
      end
   end

`ifdef MEM_STALL_CNT_EN
   logic [31:0] stall_q;

   // Saturating count of cycles spent waiting on the data cache
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         stall_q <= '0;
      end else if (mem_stall && (stall_q != 32'hFFFF_FFFF)) begin
         stall_q <= stall_q + 32'd1;
      end
   end

   assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed and randomized self-checking bench for mem_stage
`timescale 1ns/1ps
module tb_mem_stage;

   logic        CLK = 1'b0;
   logic        nRST;
   logic        ihit, flush;
   logic [31:0] nPC_next, ALUOut_next, storeData;
   logic        dREN_next, dWEN_next, regWr_next;
   logic [1:0]  regSel_next;
   logic [4:0]  regDst_next;
   logic        mem_stall;
   logic [31:0] wb_nPC, wb_ALUOut, wb_dload;
   logic        wb_regWr;
   logic [1:0]  wb_regSel;
   logic [4:0]  wb_regDst;
`ifdef MEM_STALL_CNT_EN
   logic [31:0] stall_cnt;
`endif

   mem_stage_if #(.WORD_W(32)) dbus ();

   mem_stage dut (
      .CLK(CLK), .nRST(nRST), .ihit(ihit), .flush(flush),
      .nPC_next(nPC_next), .dREN_next(dREN_next), .dWEN_next(dWEN_next),
      .regWr_next(regWr_next), .regSel_next(regSel_next), .regDst_next(regDst_next),
      .ALUOut_next(ALUOut_next), .storeData(storeData), .dbus(dbus),
      .mem_stall(mem_stall), .wb_nPC(wb_nPC), .wb_ALUOut(wb_ALUOut), .wb_dload(wb_dload),
      .wb_regWr(wb_regWr), .wb_regSel(wb_regSel), .wb_regDst(wb_regDst)
`ifdef MEM_STALL_CNT_EN
      , .stall_cnt(stall_cnt)
`endif
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [31:0] npc;
      logic [31:0] alu;
      logic [31:0] sd;
      logic        regwr;
      logic [1:0]  rsel;
      logic [4:0]  rdst;
   } ent_t;

   int          errors = 0;
   int          checks = 0;
   ent_t        prev;
   logic [31:0] hold_m;
   longint      stall_m;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_stall"}, {31'd0, mem_stall}, 32'd0);
      check({tag, "_ren"}, {31'd0, dbus.dmemREN}, 32'd0);
      check({tag, "_wen"}, {31'd0, dbus.dmemWEN}, 32'd0);
      check({tag, "_addr"}, dbus.dmemaddr, 32'd0);
      check({tag, "_store"}, dbus.dmemstore, 32'd0);
      check({tag, "_wbnpc"}, wb_nPC, 32'd0);
      check({tag, "_wbalu"}, wb_ALUOut, 32'd0);
      check({tag, "_wbdload"}, wb_dload, 32'd0);
      check({tag, "_wbctl"}, {24'd0, wb_regWr, wb_regSel, wb_regDst}, 32'd0);
   endtask

   task automatic model_reset();
      prev    = '{npc: 32'd0, alu: 32'd0, sd: 32'd0, regwr: 1'b0, rsel: 2'd0, rdst: 5'd0};
      hold_m  = 32'd0;
      stall_m = 0;
   endtask

   task automatic randomize_next();
      nPC_next    = $urandom;
      ALUOut_next = $urandom;
      storeData   = $urandom;
      dREN_next   = 1'($urandom);
      dWEN_next   = 1'($urandom);
      regWr_next  = 1'($urandom);
      regSel_next = 2'($urandom);
      regDst_next = 5'($urandom);
   endtask

   // One instruction through the stage: entered at a negedge with the stage not stalled,
   // cache acknowledges in the delay-th request cycle, then idle cycles with ihit low.
   task automatic issue(input logic [31:0] npc, input logic [31:0] alu, input logic [31:0] sd,
                        input logic dren, input logic dwen, input logic regwr,
                        input logic [1:0] rsel, input logic [4:0] rdst, input logic fl,
                        input int delay, input int idle, input logic [31:0] rdata);
      ent_t cur;
      logic is_mem, is_wr, is_rd;
      nPC_next = npc; ALUOut_next = alu; storeData = sd;
      dREN_next = dren; dWEN_next = dwen; regWr_next = regwr;
      regSel_next = rsel; regDst_next = rdst;
      flush = fl; ihit = 1'b1; dbus.dhit = 1'b0; dbus.dmemload = $urandom;
      @(posedge CLK); #1;
      check("wb_nPC", wb_nPC, prev.npc);
      check("wb_ALUOut", wb_ALUOut, prev.alu);
      check("wb_regWr", {31'd0, wb_regWr}, {31'd0, prev.regwr});
      check("wb_regSel", {30'd0, wb_regSel}, {30'd0, prev.rsel});
      check("wb_regDst", {27'd0, wb_regDst}, {27'd0, prev.rdst});
      check("wb_dload", wb_dload, hold_m);
      if (fl) cur = '{npc: 32'd0, alu: 32'd0, sd: 32'd0, regwr: 1'b0, rsel: 2'd0, rdst: 5'd0};
      else    cur = '{npc: npc, alu: alu, sd: sd, regwr: regwr, rsel: rsel, rdst: rdst};
      is_mem = !fl && (dren || dwen);
      is_wr  = !fl && dwen;
      is_rd  = is_mem && !is_wr;
      check("entry_stall", {31'd0, mem_stall}, {31'd0, is_mem});
      check("entry_addr", dbus.dmemaddr, cur.alu);
      check("entry_store", dbus.dmemstore, cur.sd);
      if (is_mem) begin
         for (int k = 1; k <= delay; k++) begin
            @(negedge CLK);
            check("wait_stall", {31'd0, mem_stall}, 32'd1);
            check("wait_ren", {31'd0, dbus.dmemREN}, {31'd0, is_rd});
            check("wait_wen", {31'd0, dbus.dmemWEN}, {31'd0, is_wr});
            check("wait_addr", dbus.dmemaddr, cur.alu);
            check("wait_store", dbus.dmemstore, cur.sd);
            randomize_next();
            ihit = 1'($urandom);
            flush = 1'b1;
            dbus.dhit = (k == delay);
            dbus.dmemload = (k == delay) ? rdata : $urandom;
         end
         if (is_rd) hold_m = rdata;
         stall_m = stall_m + delay;
         if (stall_m > 64'hFFFF_FFFF) stall_m = 64'hFFFF_FFFF;
      end
      @(negedge CLK);
      dbus.dhit = 1'b0;
      flush = 1'b0;
      check("post_stall", {31'd0, mem_stall}, 32'd0);
      check("post_req", {30'd0, dbus.dmemREN, dbus.dmemWEN}, 32'd0);
      for (int j = 0; j < idle; j++) begin
         ihit = 1'b0;
         dbus.dhit = 1'($urandom);
         dbus.dmemload = $urandom;
         @(negedge CLK);
         check("idle_stall", {31'd0, mem_stall}, 32'd0);
         check("idle_req", {30'd0, dbus.dmemREN, dbus.dmemWEN}, 32'd0);
         check("idle_addr", dbus.dmemaddr, cur.alu);
      end
      dbus.dhit = 1'b0;
`ifdef MEM_STALL_CNT_EN
      check("stall_cnt", stall_cnt, stall_m[31:0]);
`endif
      prev = cur;
   endtask

   initial begin
      model_reset();
      nRST = 1'b0; ihit = 1'b1; flush = 1'b0;
      nPC_next = 32'h4; ALUOut_next = 32'hDEAD_BEEF; storeData = 32'h5555_AAAA;
      dREN_next = 1'b1; dWEN_next = 1'b0; regWr_next = 1'b1;
      regSel_next = 2'd1; regDst_next = 5'd3;
      dbus.dhit = 1'b1; dbus.dmemload = 32'h1111_2222;
      @(negedge CLK);
      check_all_zero("rst");
      @(negedge CLK);
      check_all_zero("rst2");
      ihit = 1'b0; dbus.dhit = 1'b0;
      nRST = 1'b1;
      repeat (3) @(negedge CLK);
      check_all_zero("rel");
`ifdef MEM_STALL_CNT_EN
      check("rst_cnt", stall_cnt, 32'd0);
`endif

      // ALU pass-through, then load with 3 wait cycles, store acknowledged at once
      issue(32'h104, 32'h10, 32'h0, 1'b0, 1'b0, 1'b1, 2'd0, 5'd5, 1'b0, 0, 0, 32'h0);
      issue(32'h108, 32'h20, 32'h0, 1'b0, 1'b0, 1'b1, 2'd2, 5'd6, 1'b0, 0, 0, 32'h0);
      issue(32'h10C, 32'h100, 32'h0, 1'b1, 1'b0, 1'b1, 2'd1, 5'd7, 1'b0, 3, 0, 32'hCAFE);
      issue(32'h110, 32'h200, 32'h1234, 1'b0, 1'b1, 1'b0, 2'd0, 5'd0, 1'b0, 1, 0, 32'h0);
      // flushed load, load with flush held across WAIT and ihit low in DONE, both-enable access
      issue(32'h114, 32'h300, 32'h0, 1'b1, 1'b0, 1'b1, 2'd1, 5'd8, 1'b1, 0, 2, 32'h0);
      issue(32'h118, 32'h400, 32'h0, 1'b1, 1'b0, 1'b1, 2'd1, 5'd9, 1'b0, 5, 3, 32'hBEEF_0001);
      issue(32'h11C, 32'h500, 32'h77, 1'b1, 1'b1, 1'b0, 2'd0, 5'd10, 1'b0, 2, 1, 32'h9999);
      issue(32'h120, 32'h600, 32'h0, 1'b0, 1'b0, 1'b1, 2'd3, 5'd11, 1'b0, 0, 0, 32'h0);

      for (int n = 0; n < 40; n++) begin
         issue($urandom, $urandom, $urandom, ($urandom % 3) == 0, ($urandom % 4) == 0,
               1'($urandom), 2'($urandom), 5'($urandom), ($urandom % 5) == 0,
               int'($urandom_range(1, 5)), int'($urandom_range(0, 2)), $urandom);
      end

      // asynchronous reset in the middle of an outstanding request
      nPC_next = 32'h700; ALUOut_next = 32'h800; dREN_next = 1'b1; dWEN_next = 1'b0;
      flush = 1'b0; ihit = 1'b1; dbus.dhit = 1'b0;
      @(posedge CLK);
      @(negedge CLK);
      check("wait_before_rst", {31'd0, dbus.dmemREN}, 32'd1);
      #2 nRST = 1'b0;
      #1 check_all_zero("async_rst");
      @(negedge CLK);
      nRST = 1'b1;
      model_reset();
`ifdef MEM_STALL_CNT_EN
      force dut.stall_q = 32'hFFFF_FFFF;
      @(negedge CLK);
      release dut.stall_q;
      stall_m = 64'hFFFF_FFFF;
`endif
      issue(32'h900, 32'hA00, 32'h0, 1'b1, 1'b0, 1'b1, 2'd1, 5'd12, 1'b0, 2, 0, 32'h4242);
      issue(32'h904, 32'hA04, 32'h0, 1'b0, 1'b0, 1'b1, 2'd0, 5'd13, 1'b0, 0, 0, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
